// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for the WJBOT RISC-V core with memory handshake, timeout and trap states.
// Define WJBOT_UPPER_JUMP_EN to sequence lui/auipc/jalr; without it those opcodes trap as illegal.
module rv_multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam bit                TO_EN     = (TIMEOUT != 0);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADR   = 5'd2,
        S_MEMREAD  = 5'd3,
        S_MEMWB    = 5'd4,
        S_MEMWRITE = 5'd5,
        S_EXECR    = 5'd6,
        S_EXECI    = 5'd7,
        S_ALUWB    = 5'd8,
        S_BRANCH   = 5'd9,
        S_JAL      = 5'd10,
        S_LUI      = 5'd11,
        S_AUIPC    = 5'd12,
        S_JALR1    = 5'd13,
        S_JALR2    = 5'd14,
        S_ILLEGAL  = 5'd15,
        S_BUSERR   = 5'd16
    } state_t;

    state_t            state_r;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              wait_active;
    logic              timeout_hit;
    logic              retire;

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic slt, input logic sltu);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = slt;
            3'b101:  t = ~slt;
            3'b110:  t = sltu;
            3'b111:  t = ~sltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign timeout_hit = TO_EN && (wait_cnt_r == WAIT_LAST);
    assign illegal     = (state_r == S_ILLEGAL);
    assign bus_err     = (state_r == S_BUSERR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next;
        end
    end

    // Memory wait counter: counts consecutive unready cycles within one waiting state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_active && !mem_ready && (state_next == state_r)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= {CNT_W{1'b0}};
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end else begin
            instret <= instret;
        end
    end

    // Immediate format select straight from the opcode.
    always_comb begin
        case (op)
            OP_SW:            imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next  = state_r;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        wait_active = 1'b0;
        retire      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                wait_active = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_BUSERR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BR: begin
                        if (funct3[2:1] == 2'b01) begin
                            state_next = S_ILLEGAL;
                        end else begin
                            state_next = S_BRANCH;
                        end
                    end
                    OP_JAL:       state_next = S_JAL;
`ifdef WJBOT_UPPER_JUMP_EN
                    OP_JALR:      state_next = S_JALR1;
                    OP_LUI:       state_next = S_LUI;
                    OP_AUIPC:     state_next = S_AUIPC;
`endif
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LW) begin
                    state_next = S_MEMREAD;
                end else begin
                    state_next = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req     = 1'b1;
                adr_src     = 1'b1;
                wait_active = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next = S_BUSERR;
                end else begin
                    state_next = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req     = 1'b1;
                mem_write   = 1'b1;
                adr_src     = 1'b1;
                wait_active = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_BUSERR;
                end else begin
                    state_next = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = branch_taken(funct3, zero, lt, ltu);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef WJBOT_UPPER_JUMP_EN
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                state_next = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = S_JALR2;
            end
            S_JALR2: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
`endif
            S_ILLEGAL: state_next = S_ILLEGAL;
            S_BUSERR:  state_next = S_BUSERR;
            default:   state_next = S_ILLEGAL;
        endcase
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: vector table, corner sequences and a
// randomized run scored against a per-instruction latency/strobe-count model.
module tb_rv_multicycle_ctrl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       op = OP_R;
    logic [2:0]       funct3 = 3'b000;
    logic             zero = 1'b0;
    logic             lt = 1'b0;
    logic             ltu = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]       imm_src;
    logic             illegal, bus_err;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;
    int model_instret = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal), .bus_err(bus_err),
        .instret(instret)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       lt;
        logic       ltu;
        int         fs;
        int         ms;
    } instr_t;

    typedef struct {
        int         cycles;
        int         regw;
        int         pcw;
        int         memw;
        int         irw;
        int         functc;
        logic [2:0] imm;
    } obs_t;

    typedef struct {
        instr_t in;
        obs_t   exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_instret = 0;
    endtask

    // Reference: whole-instruction latency and strobe counts from the instruction class.
    function automatic obs_t model(input instr_t i);
        obs_t e;
        bit   taken;
        case (i.f3)
            3'b000:  taken = i.z;
            3'b001:  taken = !i.z;
            3'b100:  taken = i.lt;
            3'b101:  taken = !i.lt;
            3'b110:  taken = i.ltu;
            3'b111:  taken = !i.ltu;
            default: taken = 1'b0;
        endcase
        e = '{cycles: 0, regw: 1, pcw: 1, memw: 0, irw: 1, functc: 0, imm: 3'b000};
        case (i.op)
            OP_R, OP_I: begin e.cycles = 4 + i.fs; e.functc = 1; end
            OP_LW:      e.cycles = 5 + i.fs + i.ms;
            OP_SW:      begin e.cycles = 4 + i.fs + i.ms; e.regw = 0; e.memw = i.ms + 1; e.imm = 3'b001; end
            OP_BR:      begin e.cycles = 3 + i.fs; e.regw = 0; e.pcw = taken ? 2 : 1; e.imm = 3'b010; end
            OP_JAL:     begin e.cycles = 4 + i.fs; e.pcw = 2; e.imm = 3'b011; end
            OP_JALR:    begin e.cycles = 5 + i.fs; e.pcw = 2; end
            OP_LUI, OP_AUIPC: begin e.cycles = 4 + i.fs; e.imm = 3'b100; end
            default:    e.cycles = 0;
        endcase
        return e;
    endfunction

    // Run one instruction from its first FETCH cycle up to the next instruction's FETCH,
    // acting as a memory that answers each access after the requested number of stalls.
    task automatic run_instr(input instr_t i, output obs_t o, output bit ok);
        int   ep = 0;
        int   wcnt = 0;
        int   cyc = 0;
        logic prev_req = 1'b0;
        logic prev_adr = 1'b0;
        bit   done = 1'b0;
        o  = '{cycles: 0, regw: 0, pcw: 0, memw: 0, irw: 0, functc: 0, imm: 3'b000};
        ok = 1'b0;
        op = i.op; funct3 = i.f3; zero = i.z; lt = i.lt; ltu = i.ltu;
        while (!done && cyc < 80) begin
            if (mem_req && (!prev_req || adr_src != prev_adr)) begin
                if (!adr_src && ep >= 1) begin
                    done = 1'b1;
                    ok   = 1'b1;
                end else begin
                    ep++;
                    wcnt = 0;
                end
            end
            if (!done) begin
                prev_req = mem_req;
                prev_adr = adr_src;
                if (mem_req) begin
                    mem_ready = (wcnt >= ((ep == 1) ? i.fs : i.ms));
                    wcnt++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #2;
                if (cyc == 0) o.imm = imm_src;
                o.regw   += int'(reg_write);
                o.pcw    += int'(pc_write);
                o.memw   += int'(mem_write && mem_req);
                o.irw    += int'(ir_write);
                o.functc += int'(alu_op == 2'b10);
                cyc++;
                next_cycle();
            end
        end
        o.cycles = cyc;
    endtask

    task automatic check_instr(input string name, input instr_t i, input obs_t e);
        obs_t o;
        bit   ok;
        run_instr(i, o, ok);
        chk({name, " completes"}, int'(ok), 1);
        if (ok) begin
            model_instret = (model_instret + 1) % (1 << CNT_W);
            chk({name, " cycles"}, o.cycles, e.cycles);
            chk({name, " reg_write"}, o.regw, e.regw);
            chk({name, " pc_write"}, o.pcw, e.pcw);
            chk({name, " mem_write"}, o.memw, e.memw);
            chk({name, " ir_write"}, o.irw, e.irw);
            chk({name, " alu_op10"}, o.functc, e.functc);
            if (i.op != OP_R) chk({name, " imm_src"}, int'(o.imm), int'(e.imm));
            chk({name, " instret"}, int'(instret), model_instret);
        end
    endtask

    task automatic check_trap(input string name, input logic [6:0] o7, input logic [2:0] f3);
        op = o7; funct3 = f3;
        for (int c = 1; c <= 13; c++) begin
            mem_ready = 1'b1;
            #2;
            if (c == 2) chk({name, " not yet illegal"}, int'(illegal), 0);
            if (c >= 3) begin
                chk({name, " illegal"}, int'(illegal), 1);
                chk({name, " strobes quiet"}, int'({mem_req, pc_write, reg_write, ir_write}), 0);
            end
            next_cycle();
        end
        chk({name, " no retire"}, int'(instret), model_instret);
    endtask

    initial begin
        vec_t        tbl[14];
        logic [6:0]  ops[$];
        logic [2:0]  bf3[6];
        logic [6:0]  trap_ops[3];
        instr_t      ri;

        tbl[0]  = '{'{OP_R,   3'b000, 1'b0, 1'b0, 1'b0, 0, 0},  '{4, 1, 1, 0, 1, 1, 3'b000}};
        tbl[1]  = '{'{OP_I,   3'b000, 1'b0, 1'b0, 1'b0, 2, 0},  '{6, 1, 1, 0, 1, 1, 3'b000}};
        tbl[2]  = '{'{OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, 0, 3},  '{8, 1, 1, 0, 1, 0, 3'b000}};
        tbl[3]  = '{'{OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 1, 1},  '{6, 0, 1, 2, 1, 0, 3'b001}};
        tbl[4]  = '{'{OP_BR,  3'b000, 1'b1, 1'b0, 1'b0, 0, 0},  '{3, 0, 2, 0, 1, 0, 3'b010}};
        tbl[5]  = '{'{OP_BR,  3'b001, 1'b1, 1'b0, 1'b0, 0, 0},  '{3, 0, 1, 0, 1, 0, 3'b010}};
        tbl[6]  = '{'{OP_BR,  3'b110, 1'b0, 1'b0, 1'b1, 0, 0},  '{3, 0, 2, 0, 1, 0, 3'b010}};
        tbl[7]  = '{'{OP_BR,  3'b100, 1'b0, 1'b0, 1'b0, 0, 0},  '{3, 0, 1, 0, 1, 0, 3'b010}};
        tbl[8]  = '{'{OP_BR,  3'b101, 1'b0, 1'b0, 1'b0, 0, 0},  '{3, 0, 2, 0, 1, 0, 3'b010}};
        tbl[9]  = '{'{OP_BR,  3'b111, 1'b0, 1'b0, 1'b1, 0, 0},  '{3, 0, 1, 0, 1, 0, 3'b010}};
        tbl[10] = '{'{OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0},  '{4, 1, 2, 0, 1, 0, 3'b011}};
        tbl[11] = '{'{OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, 14, 14}, '{33, 1, 1, 0, 1, 0, 3'b000}};
        tbl[12] = '{'{OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 0, 14}, '{18, 0, 1, 15, 1, 0, 3'b001}};
        tbl[13] = '{'{OP_BR,  3'b100, 1'b0, 1'b1, 1'b0, 3, 0},  '{6, 0, 2, 0, 1, 0, 3'b010}};

        // Reset state, sampled while reset is still held.
        repeat (2) @(posedge clk);
        #3;
        chk("rst mem_req", int'(mem_req), 1);
        chk("rst adr_src", int'(adr_src), 0);
        chk("rst alu_src_b", int'(alu_src_b), 2);
        chk("rst result_src", int'(result_src), 2);
        chk("rst reg_write", int'(reg_write), 0);
        chk("rst instret", int'(instret), 0);
        chk("rst flags", int'({illegal, bus_err}), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int v = 0; v < 14; v++) check_instr($sformatf("vec%0d", v), tbl[v].in, tbl[v].exp);

        check_trap("beq f3=010", OP_BR, 3'b010);

        // Fetch timeout after some retirements; reset must clear bus_err and instret.
        do_reset();
        chk("post-trap reset illegal", int'(illegal), 0);
        for (int k = 0; k < 3; k++) check_instr("pre-timeout add", tbl[0].in, tbl[0].exp);
        for (int c = 1; c <= 16; c++) begin
            mem_ready = 1'b0;
            #2;
            if (c == 15) chk("fetch timeout c15 bus_err", int'(bus_err), 0);
            if (c == 16) begin
                chk("fetch timeout c16 bus_err", int'(bus_err), 1);
                chk("buserr mem_req", int'(mem_req), 0);
            end
            next_cycle();
        end
        chk("buserr no retire", int'(instret), 3);
        do_reset();
        chk("reset clears bus_err", int'(bus_err), 0);
        chk("reset clears instret", int'(instret), 0);

        // Data-phase timeout on a load that never completes.
        op = OP_LW; funct3 = 3'b010;
        for (int c = 1; c <= 19; c++) begin
            mem_ready = (c == 1);
            #2;
            if (c == 18) begin
                chk("load timeout c18 bus_err", int'(bus_err), 0);
                chk("load timeout c18 adr_src", int'(adr_src), 1);
            end
            if (c == 19) chk("load timeout c19 bus_err", int'(bus_err), 1);
            next_cycle();
        end

        // Counter wrap at 2^CNT_W retirements.
        do_reset();
        for (int k = 0; k < 16; k++) check_instr("wrap add", tbl[0].in, tbl[0].exp);
        chk("instret wrapped", int'(instret), 0);

        // Upper-immediate and indirect-jump opcodes.
        trap_ops = '{OP_JALR, OP_LUI, OP_AUIPC};
`ifdef WJBOT_UPPER_JUMP_EN
        do_reset();
        check_instr("jalr", '{OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0}, '{5, 1, 2, 0, 1, 0, 3'b000});
        check_instr("lui", '{OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0}, '{5, 1, 1, 0, 1, 0, 3'b100});
        check_instr("auipc", '{OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0}, '{4, 1, 1, 0, 1, 0, 3'b100});
`else
        for (int t = 0; t < 3; t++) begin
            do_reset();
            check_trap($sformatf("upper op%0d", t), trap_ops[t], 3'b000);
        end
`endif

        // Reset landing while a load waits in its memory phase.
        do_reset();
        check_instr("sw before mid reset", '{OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0}, '{4, 0, 1, 1, 1, 0, 3'b001});
        op = OP_LW; funct3 = 3'b010;
        for (int c = 1; c <= 5; c++) begin
            mem_ready = (c == 1);
            next_cycle();
        end
        chk("mid load adr_src", int'(adr_src), 1);
        reset = 1'b1;
        #1;
        chk("mid reset adr_src", int'(adr_src), 0);
        chk("mid reset mem_req", int'(mem_req), 1);
        chk("mid reset instret", int'(instret), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_instret = 0;
        check_instr("add after mid reset", tbl[0].in, tbl[0].exp);

        // Randomized instruction stream against the model.
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL};
`ifdef WJBOT_UPPER_JUMP_EN
        ops.push_back(OP_JALR);
        ops.push_back(OP_LUI);
        ops.push_back(OP_AUIPC);
`endif
        bf3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        do_reset();
        for (int n = 0; n < 250; n++) begin
            ri.op  = ops[$urandom_range(0, ops.size() - 1)];
            ri.f3  = (ri.op == OP_BR) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            ri.z   = 1'($urandom_range(0, 1));
            ri.lt  = 1'($urandom_range(0, 1));
            ri.ltu = 1'($urandom_range(0, 1));
            ri.fs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
            ri.ms  = int'($urandom_range(0, 14));
            check_instr($sformatf("rand%0d op=%b f3=%b", n, ri.op, ri.f3), ri, model(ri));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
